seg7_scan_mux: RTL and testbench

SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/seg7_font.sv | 17 +
 rtl/seg7_scan_mux.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_mux.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the two-digit seven-segment scan multiplexer:
//   - state_t    : scan FSM states, visited in fixed cyclic order
//   - SEG_OFF    : active-low pattern with every segment dark
//   - FONT_TABLE : active-low glyphs for digits 0-9, bit 0 = a ... bit 6 = g
//   - font_lookup: digit -> glyph; anything above 9 is shown dark
package seg7_pkg;

    typedef enum logic [1:0] {
        S_UNITS   = 2'd0,
        S_BLANK_U = 2'd1,
        S_TENS    = 2'd2,
        S_BLANK_T = 2'd3
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Packed table, element [0] is the rightmost entry of the concatenation.
    localparam logic [9:0][6:0] FONT_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    function automatic logic [6:0] font_lookup(input logic [3:0] digit);
        logic [6:0] glyph;
        glyph = SEG_OFF;
        if (digit <= 4'd9) begin
            glyph = FONT_TABLE[digit];
        end
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_font.sv
// seg7_font
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   digit : in  [3:0] digit value 0-9 (10-15 decode to all segments dark)
//   seg_n : out [6:0] active-low segments, seg_n[0]=a ... seg_n[6]=g
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = font_lookup(digit);
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Time-multiplexes a 0-15 value onto a two-digit common-segment display.
// Each frame: units digit, dark gap, tens digit, dark gap. The value is
// captured only at frame start so a frame never mixes two values.
// Ports:
//   clk        : in  system clock, rising edge
//   rst_n      : in  asynchronous active-low reset
//   binary     : in  [3:0] value to show, asynchronous to clk
//   seg        : out [6:0] active-low segments, seg[0]=a ... seg[6]=g
//   uni        : out units-digit enable, active-high
//   dec        : out tens-digit enable, active-high
//   frame_tick : out one-cycle pulse in the first cycle of each frame
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 27000,
    parameter int BLANK_CYCLES = 270,
    parameter int LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] binary,
    output logic [6:0] seg,
    output logic       uni,
    output logic       dec,
    output logic       frame_tick
);

    generate
        if (DIGIT_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_timing
            $error("seg7_scan_mux: DIGIT_CYCLES and BLANK_CYCLES must both be >= 1");
        end
    endgenerate

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic [6:0]       seg_q, seg_d;
    logic             uni_q, uni_d;
    logic             dec_q, dec_d;
    logic             tick_q, tick_d;

    logic [CNT_W-1:0] cnt_last;
    logic [3:0]       digit_sel;
    logic             blank_sel;
    logic [6:0]       font_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BLANK_T;
            cnt_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            tens_q  <= '0;
            units_q <= '0;
            seg_q   <= SEG_OFF;
            uni_q   <= 1'b0;
            dec_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            seg_q   <= seg_d;
            uni_q   <= uni_d;
            dec_q   <= dec_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state, counter and display-register update.
    always_comb begin
        sync1_d = binary;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        tens_d  = tens_q;
        units_d = units_q;
        tick_d  = 1'b0;

        if (state_q == S_UNITS || state_q == S_TENS) begin
            cnt_last = DIGIT_LAST;
        end else begin
            cnt_last = BLANK_LAST;
        end

        if (cnt_q == cnt_last) begin
            cnt_d = '0;
            case (state_q)
                S_UNITS:   state_d = S_BLANK_U;
                S_BLANK_U: state_d = S_TENS;
                S_TENS:    state_d = S_BLANK_T;
                S_BLANK_T: begin
                    // Only point where the shown value changes.
                    state_d = S_UNITS;
                    tick_d  = 1'b1;
                    if (sync2_q >= 4'd10) begin
                        tens_d  = 4'd1;
                        units_d = sync2_q - 4'd10;
                    end else begin
                        tens_d  = 4'd0;
                        units_d = sync2_q;
                    end
                end
                default:   state_d = S_BLANK_T;
            endcase
        end
    end

    // Output stage. The digit mux looks at the state and display value the
    // registers are about to take, so the glyph and its enable land in their
    // output flops on the same edge as the state change.
    always_comb begin
        digit_sel = units_d;
        blank_sel = 1'b1;
        uni_d     = 1'b0;
        dec_d     = 1'b0;
        case (state_d)
            S_UNITS: begin
                digit_sel = units_d;
                blank_sel = 1'b0;
                uni_d     = 1'b1;
            end
            S_TENS: begin
                digit_sel = tens_d;
                if (!((LZ_BLANK != 0) && (tens_d == 4'd0))) begin
                    blank_sel = 1'b0;
                    dec_d     = 1'b1;
                end
            end
            default: begin
                blank_sel = 1'b1;
            end
        endcase
        seg_d = blank_sel ? SEG_OFF : font_seg;
    end

    seg7_font u_font (
        .digit (digit_sel),
        .seg_n (font_seg)
    );

    assign seg        = seg_q;
    assign uni        = uni_q;
    assign dec        = dec_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with DIGIT_CYCLES=4, BLANK_CYCLES=1.
// Two instances share clock, reset and input: one with leading-zero
// blanking, one without. Outputs are sampled on the falling edge.
module tb_seg7_scan_mux;

    logic       clk;
    logic       rst_n;
    logic [3:0] binary;

    logic [6:0] seg_a, seg_b;
    logic       uni_a, uni_b;
    logic       dec_a, dec_b;
    logic       tick_a, tick_b;

    logic [9:0] obs_a, obs_b;
    assign obs_a = {tick_a, uni_a, dec_a, seg_a};
    assign obs_b = {tick_b, uni_b, dec_b, seg_b};

    int checks = 0;
    int errors = 0;

    seg7_scan_mux #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .LZ_BLANK(1)) u_lz (
        .clk        (clk),
        .rst_n      (rst_n),
        .binary     (binary),
        .seg        (seg_a),
        .uni        (uni_a),
        .dec        (dec_a),
        .frame_tick (tick_a)
    );

    seg7_scan_mux #(.DIGIT_CYCLES(4), .BLANK_CYCLES(1), .LZ_BLANK(0)) u_nolz (
        .clk        (clk),
        .rst_n      (rst_n),
        .binary     (binary),
        .seg        (seg_b),
        .uni        (uni_b),
        .dec        (dec_b),
        .frame_tick (tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Positioned on the falling edge of a frame's first cycle. Checks all
    // ten cycles of both instances and leaves the bench on the first cycle
    // of the following frame. Optionally changes binary after cycle chg_cyc.
    task automatic run_frame(input string tag,
                             input logic [6:0] u_seg,
                             input logic [6:0] ta_seg, input logic ta_dec,
                             input logic [6:0] tb_seg, input logic tb_dec,
                             input int chg_cyc, input logic [3:0] chg_val);
        logic [9:0] exp_a, exp_b;
        for (int k = 1; k <= 10; k++) begin
            if (k <= 4) begin
                exp_a = {(k == 1), 1'b1, 1'b0, u_seg};
                exp_b = exp_a;
            end else if (k == 5 || k == 10) begin
                exp_a = {3'b000, 7'h7F};
                exp_b = exp_a;
            end else begin
                exp_a = {2'b00, ta_dec, ta_seg};
                exp_b = {2'b00, tb_dec, tb_seg};
            end
            check($sformatf("%s_lz_c%0d", tag, k), 32'(obs_a), 32'(exp_a));
            check($sformatf("%s_nolz_c%0d", tag, k), 32'(obs_b), 32'(exp_b));
            if (k == chg_cyc) binary = chg_val;
            @(negedge clk);
        end
    endtask

    // Continuous checks for the random phase.
    logic mon_en   = 1'b0;
    int   mon_cyc  = 0;
    int   last_tick = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            check("mon_excl_lz", 32'(uni_a & dec_a), 32'd0);
            check("mon_excl_nolz", 32'(uni_b & dec_b), 32'd0);
            if (!uni_a && !dec_a) check("mon_dark_lz", 32'(seg_a), 32'h7F);
            if (!uni_b && !dec_b) check("mon_dark_nolz", 32'(seg_b), 32'h7F);
            check("mon_tick_align", 32'(tick_a), 32'(tick_b));
            if (tick_a) begin
                if (last_tick >= 0) check("mon_period", 32'(mon_cyc - last_tick), 32'd10);
                last_tick = mon_cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        rst_n  = 1'b0;
        binary = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_lz", 32'(obs_a), 32'h07F);
        check("reset_nolz", 32'(obs_b), 32'h07F);

        // Release: first tick after BLANK_CYCLES, value 0.
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("zero", 7'h40, 7'h7F, 1'b0, 7'h40, 1'b1, 0, 4'd0);

        binary = 4'd15;
        repeat (10) @(negedge clk);
        run_frame("v15", 7'h12, 7'h79, 1'b1, 7'h79, 1'b1, 0, 4'd0);

        binary = 4'd12;
        repeat (10) @(negedge clk);
        run_frame("v12", 7'h24, 7'h79, 1'b1, 7'h79, 1'b1, 0, 4'd0);

        binary = 4'd7;
        repeat (10) @(negedge clk);
        run_frame("v7", 7'h78, 7'h7F, 1'b0, 7'h40, 1'b1, 0, 4'd0);

        // Mid-frame change 3 -> 9: current frame keeps 3, next shows 9.
        binary = 4'd3;
        repeat (10) @(negedge clk);
        run_frame("v3_hold", 7'h30, 7'h7F, 1'b0, 7'h40, 1'b1, 2, 4'd9);
        run_frame("v9", 7'h10, 7'h7F, 1'b0, 7'h40, 1'b1, 0, 4'd0);

        // Reset pulse in the middle of the tens digit.
        binary = 4'd15;
        repeat (10) @(negedge clk);
        repeat (6) @(negedge clk);
        check("pre_rst_tens_lz", 32'(obs_a), 32'h079 | 32'h080);
        rst_n  = 1'b0;
        #1;
        check("rst_async_lz", 32'(obs_a), 32'h07F);
        check("rst_async_nolz", 32'(obs_b), 32'h07F);
        binary = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("restart", 7'h40, 7'h7F, 1'b0, 7'h40, 1'b1, 0, 4'd0);

        // 1000 frames of random input under the continuous monitor.
        ticks  = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (tick_a) ticks++;
            if ($urandom_range(0, 6) == 0) binary = 4'($urandom_range(0, 15));
        end
        mon_en = 1'b0;
        check("random_frame_count", 32'(ticks), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
